// File: rtl/fft_bin_reader_if.sv
// Bus between the FFT result stream, the bin reader and the downstream feature logic.
// The master modport is the driving environment; the slave modport is the reader itself.
interface fft_bin_reader_if #(
  parameter int OWIDTH = 21,
  parameter int LGFFT  = 8
);
  logic                  i_ce;
  logic [2*OWIDTH-1:0]   i_result;
  logic                  i_sync;
  // Handshake: a result transfers on every clock where o_valid && i_ready. Once
  // o_valid is high the head (o_power/o_bin/o_last) stays stable until it transfers.
  logic                  o_valid;
  logic                  i_ready;
  logic [2*OWIDTH-1:0]   o_power;
  logic [LGFFT-1:0]      o_bin;
  logic                  o_last;
  logic                  o_overflow;
  logic                  o_sync_err;

  modport master (
    output i_ce, i_result, i_sync, i_ready,
    input  o_valid, o_power, o_bin, o_last, o_overflow, o_sync_err
  );

  modport slave (
    input  i_ce, i_result, i_sync, i_ready,
    output o_valid, o_power, o_bin, o_last, o_overflow, o_sync_err
  );
endinterface

// File: rtl/fft_bin_reader.sv
// Frame-tracking reader for the pipelined FFT output: keeps bins 0..NBINS-1,
// computes |X|^2 and buffers results in a first-word-fall-through FIFO.
module fft_bin_reader #(
  parameter int OWIDTH = 21,
  parameter int LGFFT  = 8,
  parameter int NBINS  = 129,
  parameter int LGFIFO = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  fft_bin_reader_if.slave bus,
  output logic            o_dbg_run
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam int PW    = 2 * OWIDTH;
  localparam int EW    = 1 + LGFFT + PW;
  localparam logic [LGFFT:0]   NBINS_W  = (LGFFT+1)'(NBINS);
  localparam logic [LGFFT-1:0] LAST_BIN = LGFFT'(NBINS - 1);
  localparam logic [LGFFT-1:0] CNT_ONE  = LGFFT'(1);
  localparam logic [LGFIFO:0]  PTR_ONE  = (LGFIFO+1)'(1);

  typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LGFFT-1:0]        cnt_q, cnt_d;
  logic                    sync_err_q, sync_err_d;
  logic                    ovf_q, ovf_d;

  logic                    s0_v_q, s0_v_d, s0_last_q, s0_last_d;
  logic signed [OWIDTH-1:0] s0_re_q, s0_re_d, s0_im_q, s0_im_d;
  logic [LGFFT-1:0]        s0_bin_q, s0_bin_d;

  logic                    s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [PW-1:0]           s1_pow_q, s1_pow_d;
  logic [LGFFT-1:0]        s1_bin_q, s1_bin_d;

  logic [EW-1:0]           mem_q [DEPTH];
  logic [EW-1:0]           mem_d [DEPTH];
  logic [LGFIFO:0]         wr_q, wr_d, rd_q, rd_d;

  logic                    accept, keep, empty, full, pop, push;
  logic [LGFFT-1:0]        acc_bin;
  logic signed [PW-1:0]    re_sq, im_sq;

  // Frame tracker: decides whether the current strobe is a bin and which one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_err_q;
    accept     = 1'b0;
    acc_bin    = cnt_q;
    if (bus.i_ce) begin
      case (state_q)
        WAIT_SYNC: begin
          if (bus.i_sync) begin
            accept  = 1'b1;
            acc_bin = '0;
            cnt_d   = CNT_ONE;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.i_sync) begin
            if (cnt_q != '0) sync_err_d = 1'b1;
            accept  = 1'b1;
            acc_bin = '0;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == '0) begin
            // Wrapped without a sync: drop the sample and hunt for alignment again.
            sync_err_d = 1'b1;
            state_d    = WAIT_SYNC;
          end else begin
            accept = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
    keep = accept && ({1'b0, acc_bin} < NBINS_W);
  end

  always_comb begin
    s0_v_d    = keep;
    s0_re_d   = keep ? bus.i_result[PW-1:OWIDTH] : s0_re_q;
    s0_im_d   = keep ? bus.i_result[OWIDTH-1:0]  : s0_im_q;
    s0_bin_d  = keep ? acc_bin : s0_bin_q;
    s0_last_d = keep ? (acc_bin == LAST_BIN) : s0_last_q;

    re_sq     = s0_re_q * s0_re_q;
    im_sq     = s0_im_q * s0_im_q;
    s1_v_d    = s0_v_q;
    s1_pow_d  = s0_v_q ? $unsigned(re_sq + im_sq) : s1_pow_q;
    s1_bin_d  = s0_v_q ? s0_bin_q  : s1_bin_q;
    s1_last_d = s0_v_q ? s0_last_q : s1_last_q;
  end

  // FIFO: a full write only lands if the head leaves on the same edge.
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[LGFIFO] != rd_q[LGFIFO]) && (wr_q[LGFIFO-1:0] == rd_q[LGFIFO-1:0]);
    pop   = !empty && bus.i_ready;
    push  = s1_v_q && (!full || pop);
    ovf_d = ovf_q || (s1_v_q && full && !pop);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[LGFIFO-1:0]] = {s1_last_q, s1_bin_q, s1_pow_q};
      wr_d = wr_q + PTR_ONE;
    end
    if (pop) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_SYNC;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      s0_v_q     <= 1'b0;
      s0_re_q    <= '0;
      s0_im_q    <= '0;
      s0_bin_q   <= '0;
      s0_last_q  <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_pow_q   <= '0;
      s1_bin_q   <= '0;
      s1_last_q  <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= ovf_d;
      s0_v_q     <= s0_v_d;
      s0_re_q    <= s0_re_d;
      s0_im_q    <= s0_im_d;
      s0_bin_q   <= s0_bin_d;
      s0_last_q  <= s0_last_d;
      s1_v_q     <= s1_v_d;
      s1_pow_q   <= s1_pow_d;
      s1_bin_q   <= s1_bin_d;
      s1_last_q  <= s1_last_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.o_valid                        = !empty;
  assign {bus.o_last, bus.o_bin, bus.o_power} = mem_q[rd_q[LGFIFO-1:0]];
  assign bus.o_overflow                     = ovf_q;
  assign bus.o_sync_err                     = sync_err_q;
  assign o_dbg_run                          = (state_q == RUN);
endmodule

// File: tb/tb_fft_bin_reader.sv
// Directed-plus-random bench for fft_bin_reader; expected results come from a
// frame-level model of which bins are kept and what |X|^2 they carry.
module tb_fft_bin_reader;
  localparam int OWIDTH = 21;
  localparam int LGFFT  = 8;
  localparam int NBINS  = 129;
  localparam int LGFIFO = 4;
  localparam int N      = 1 << LGFFT;
  localparam int DEPTH  = 1 << LGFIFO;
  localparam int PW     = 2 * OWIDTH;
  localparam int W      = 1 + LGFFT + PW;

  logic i_clk = 1'b0;
  logic i_reset;
  logic dbg_run;

  fft_bin_reader_if #(.OWIDTH(OWIDTH), .LGFFT(LGFFT)) bus ();

  fft_bin_reader #(.OWIDTH(OWIDTH), .LGFFT(LGFFT), .NBINS(NBINS), .LGFIFO(LGFIFO)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .bus       (bus),
    .o_dbg_run (dbg_run)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // reference model state
  bit m_run = 0;
  int m_next = 0;
  bit m_err = 0;
  bit m_ovf = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model(input bit sync, input int re, input int im);
    int bin;
    bit keep;
    longint p;
    logic lst;
    keep = 0;
    bin  = 0;
    if (!m_run) begin
      if (sync) begin m_run = 1; keep = 1; bin = 0; m_next = 1; end
    end else if (sync) begin
      if (m_next != 0) m_err = 1;
      keep = 1; bin = 0; m_next = 1;
    end else if (m_next == 0) begin
      m_err = 1; m_run = 0;
    end else begin
      keep = 1; bin = m_next; m_next = (m_next + 1) % N;
    end
    if (keep && bin < NBINS) begin
      p   = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      lst = (bin == NBINS - 1);
      exp_q.push_back({lst, LGFFT'(bin), PW'(p)});
    end
  endtask

  // driver tasks
  task automatic send(input bit sync, input int re, input int im);
    logic [OWIDTH-1:0] r, i;
    r = OWIDTH'(re);
    i = OWIDTH'(im);
    bus.i_result = {r, i};
    bus.i_sync   = sync;
    bus.i_ce     = 1'b1;
    model(sync, re, im);
    @(posedge i_clk); #1;
    bus.i_ce   = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int t = 0; t < n; t++) begin
      bus.i_result = PW'({$urandom, $urandom});
      bus.i_sync   = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
      bus.i_sync = 1'b0;
    end
  endtask

  function automatic int rnd_comp();
    logic signed [OWIDTH-1:0] v;
    v = OWIDTH'($urandom);
    return int'(v);
  endfunction

  task automatic send_frame(input int mode, input bit gaps);
    int re, im;
    for (int k = 0; k < N; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      case (mode)
        0: begin re = k; im = -k; end
        1: begin re = rnd_comp(); im = rnd_comp(); end
        default: begin
          re = (k == 0) ? -(1 << 20) : (k == 1) ? (1 << 20) - 1 : 0;
          im = (k == 0) ? -(1 << 20) : 0;
        end
      endcase
      send(k == 0, re, im);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_sync_err"}, bus.o_sync_err, m_err);
    check({tag, "_overflow"}, bus.o_overflow, m_ovf);
  endtask

  // scoreboard: compare every transferred head against the expected queue
  always @(negedge i_clk) begin
    if (!i_reset && bus.o_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", bus.o_valid, 1'b0);
      else if (bus.i_ready) begin
        mon_e = exp_q.pop_front();
        check("power", bus.o_power, mon_e[PW-1:0]);
        check("bin",   bus.o_bin,   mon_e[PW+LGFFT-1:PW]);
        check("last",  bus.o_last,  mon_e[W-1]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ce = 1'b0; bus.i_sync = 1'b0; bus.i_result = '0; bus.i_ready = 1'b1;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_overflow", bus.o_overflow, 1'b0);
    check("rst_sync_err", bus.o_sync_err, 1'b0);
    check("rst_state", dbg_run, 1'b0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // pre-sync junk then an aligned frame with random ce gaps
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 2) == 0) tick(1);
      send(1'b0, rnd_comp(), rnd_comp());
    end
    check("presync_valid", bus.o_valid, 1'b0);
    send_frame(0, 1'b1);
    wait_drain("gaps");

    // aligned frame with first-output latency check
    send(1'b1, 0, 0);
    check("lat_e0", bus.o_valid, 1'b0);
    @(posedge i_clk); #1;
    check("lat_e1", bus.o_valid, 1'b0);
    @(posedge i_clk); #1;
    check("lat_e2", bus.o_valid, 1'b1);
    for (int k = 1; k < N; k++) send(1'b0, k, -k);
    wait_drain("aligned");

    // extreme component values
    send_frame(2, 1'b0);
    wait_drain("extreme");

    // random data frame
    send_frame(1, 1'b1);
    wait_drain("random");

    // backpressure for a whole frame
    bus.i_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      send(k == 0, k, -k);
      if (k == 17) check("ovf_before", bus.o_overflow, 1'b0);
      if (k == 18) check("ovf_at_bin16", bus.o_overflow, 1'b1);
    end
    tick(4);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    m_ovf = 1;
    bus.i_ready = 1'b1;
    wait_drain("backpressure");

    // sync arriving at bin 100
    for (int k = 0; k < 100; k++) send(k == 0, k, -k);
    check("early_err_before", bus.o_sync_err, 1'b0);
    send(1'b1, 7, 3);
    check("early_sync_err", bus.o_sync_err, 1'b1);
    for (int k = 1; k < N; k++) send(1'b0, k, -k);
    wait_drain("early_sync");

    // reset mid-stream with the FIFO half full
    bus.i_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(k == 0, k, k);
    tick(4);
    check("half_valid", bus.o_valid, 1'b1);
    #2;
    i_reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_overflow", bus.o_overflow, 1'b0);
    check("mid_rst_sync_err", bus.o_sync_err, 1'b0);
    exp_q.delete();
    m_run = 0; m_next = 0; m_err = 0; m_ovf = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 20; k++) send(1'b0, rnd_comp(), rnd_comp());
    tick(5);
    check("post_rst_idle", bus.o_valid, 1'b0);

    // missing sync at the frame wrap
    send_frame(1, 1'b0);
    for (int k = 0; k < 5; k++) send(1'b0, rnd_comp(), rnd_comp());
    check("wrap_sync_err", bus.o_sync_err, 1'b1);
    check("wrap_state", dbg_run, 1'b0);
    wait_drain("wrap");
    check("wrap_idle", bus.o_valid, 1'b0);

    // fresh frame after the alignment fault
    send_frame(0, 1'b1);
    wait_drain("resync");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_bin_reader.md
Name: fft_bin_reader

Overview:
Consumer at the output end of the 256-point pipelined FFT. Accepts the FFT's clock-enabled result stream (o_result/o_sync/i_ce), tracks the frame position, and keeps only the non-redundant bins 0..N/2. Computes |X|^2 for each kept bin and buffers it in a small FIFO. Presents the results to the downstream feature logic over a valid/ready handshake, with sticky overflow and sync-error flags.

Parameters:
OWIDTH, 21, bits per real/imag component of incoming FFT result
LGFFT, 8, log2 FFT size (frame = 2^LGFFT samples)
NBINS, 129, bins kept per frame (0..NBINS-1), must be <= 2^LGFFT
LGFIFO, 4, log2 output FIFO depth

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_ce  in  1  input sample strobe, same as FFT i_ce
i_result  in  2*OWIDTH  FFT result, real in high half, imag in low half, two's complement
i_sync  in  1  FFT o_sync, high with bin 0 of each frame
o_valid  out  1  FIFO head valid
i_ready  in  1  downstream accepts head
o_power  out  2*OWIDTH  unsigned re^2+im^2
o_bin  out  LGFFT  bin index of head
o_last  out  1  head is bin NBINS-1
o_overflow  out  1  sticky: a kept bin was dropped, FIFO full
o_sync_err  out  1  sticky: frame alignment violated

Behaviour:
- Reset (async): state WAIT_SYNC, bin counter 0, pipeline valids 0, FIFO empty, all outputs 0.
- Sample accepted only on a clock with i_ce=1. With i_ce=0, no counter or state change. The pipeline and FIFO still run.
- WAIT_SYNC state:
  - Samples are ignored until i_ce && i_sync.
  - On i_ce && i_sync: that sample is bin 0, go to RUN, and the next bin is 1.
- RUN state:
  - Each accepted sample takes the current counter value as its bin; the counter increments mod 2^LGFFT.
  - i_sync on a sample whose bin != 0: set o_sync_err, treat the sample as bin 0, reload the counter to 1.
  - Bin == 0 without i_sync: set o_sync_err, drop the sample, go to WAIT_SYNC.
- Only samples with bin < NBINS enter the pipeline; others are discarded silently.
- Pipeline is free-running, with a valid bit per stage:
  - E0 (accepting edge): latch re, im, bin, and last = (bin==NBINS-1).
  - E1: power = re*re + im*im. Signed squares, unsigned 2*OWIDTH-bit sum. Max 2^(2*OWIDTH-1) at re=im=-2^(OWIDTH-1), so there is no wrap.
  - E2: FIFO write. o_valid rises after E2 if the FIFO was empty. Latency is 3 edges.
- FIFO: 2^LGFIFO entries of {last, bin, power}, first-word-fall-through.
  - o_valid = !empty; the head is driven on o_power/o_bin/o_last.
  - Pop when o_valid && i_ready.
  - Write while full with no pop in the same cycle: entry dropped, o_overflow set, FIFO contents unchanged.
  - Write while full with a simultaneous pop: both occur, no drop.
  - Pop on empty: not possible, since o_valid=0.
- o_power/o_bin/o_last are don't-care while o_valid=0; the RTL drives the head register.
- Sticky flags clear only on reset.
- Reset mid-frame: everything clears immediately; a new frame is accepted only after the next i_sync.

Test Plan:
1. Assert i_reset mid-stream with the FIFO half full -> o_valid, o_overflow, o_sync_err = 0 immediately. The next output appears only after a fresh i_sync frame.
2. One aligned frame, i_ready=1, bin k carries re=k, im=-k -> 129 outputs: bins 0..128 in order, o_power=2k^2, o_last only at bin 128. Nothing from bins 129..255. First o_valid 3 edges after the sync sample.
3. Bin 0 with re=im=-2^20, then re=2^20-1, im=0 -> o_power = 2^41, then (2^20-1)^2.
4. Random i_ce gaps plus 50 pre-sync samples -> pre-sync samples ignored; same 129 results as scenario 2, unaffected by gaps.
5. i_ready=0 for a whole frame, LGFIFO=4 -> bins 0..15 buffered, o_overflow=1 at the bin-16 write. With i_ready=1 afterwards, bins 0..15 drain in order.
6. Alignment faults:
   - i_sync at bin 100 -> o_sync_err=1, next outputs restart at bin 0.
   - A separate run with sync missing at wrap -> o_sync_err=1, no outputs until the next i_sync.
